// File: rtl/hazard_pkg.sv
// Shared types for the ID-stage hazard scheduler: jump encodings and sequencer states.
package hazard_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        J_NONE = 2'b00,
        J_JR   = 2'b01,
        J_J    = 2'b10,
        J_JAL  = 2'b11
    } jump_t;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        DRAIN   = 2'b01,
        SC_WAIT = 2'b10,
        HALT    = 2'b11
    } sched_state_t;

endpackage

// File: rtl/hazard_scheduler_if.sv
// ID-stage handshake bundle between the pipeline front end and the hazard scheduler.
interface hazard_scheduler_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic [REG_W-1:0] id_wr_num;
    logic [1:0]       id_jump;
    logic             id_syscall;
    logic             branch_taken_ex;
    logic             syscall_done;
    logic             syscall_halt;

    logic             stall_if;
    logic             stall_id;
    logic             bubble_ex;
    logic             flush_id;
    logic             syscall_req;
    logic             halted;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_valid, id_rs, id_rt, id_wr_num, id_jump, id_syscall,
               branch_taken_ex, syscall_done, syscall_halt,
        input  stall_if, stall_id, bubble_ex, flush_id, syscall_req, halted, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_wr_num, id_jump, id_syscall,
               branch_taken_ex, syscall_done, syscall_halt,
        output stall_if, stall_id, bubble_ex, flush_id, syscall_req, halted, stall_count
    );

endinterface

// File: rtl/hazard_scoreboard.sv
// Two-deep shift of in-flight destination registers (ID/EX, EX/MEM) with RAW compare.
module hazard_scoreboard #(
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue,
    input  logic             check_en,
    input  logic [REG_W-1:0] wr_num,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    output logic             raw,
    output logic             empty
);
    logic [REG_W-1:0] sb_ex;
    logic [REG_W-1:0] sb_mem;
    logic             rs_hit;
    logic             rt_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_ex  <= '0;
            sb_mem <= '0;
        end else begin
            sb_mem <= sb_ex;
            sb_ex  <= issue ? wr_num : '0;
        end
    end

    // Register 0 is hardwired, so it never creates a dependency.
    assign rs_hit = (rs != '0) && ((rs == sb_ex) || (rs == sb_mem));
    assign rt_hit = (rt != '0) && ((rt == sb_ex) || (rt == sb_mem));
    assign raw    = check_en && (rs_hit || rt_hit);
    assign empty  = (sb_ex == '0) && (sb_mem == '0);

endmodule

// File: rtl/hazard_scheduler.sv
// ID-stage sequencer: RAW stalls, branch flushes and the syscall drain/handshake/halt sequence.
module hazard_scheduler #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic rst_n,
    hazard_scheduler_if.slave bus
);
    import hazard_pkg::*;

    sched_state_t     state;
    jump_t            jump;
    logic             raw;
    logic             sb_empty;
    logic             check_en;
    logic             issue;
    logic             retire;
    logic             stall_if;
    logic             stall_id;
    logic             bubble_ex;
    logic             flush_id;
    logic             syscall_req;
    logic             halted;
    logic [CNT_W-1:0] stall_count;

    assign jump     = jump_t'(bus.id_jump);
    assign check_en = bus.id_valid && ((jump == J_NONE) || (jump == J_JR));
    assign issue    = bus.id_valid && !stall_id && !flush_id && !halted;
    assign retire   = bus.syscall_done && !bus.syscall_halt;

    hazard_scoreboard #(.REG_W(REG_W)) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .issue    (issue),
        .check_en (check_en),
        .wr_num   (bus.id_wr_num),
        .rs       (bus.id_rs),
        .rt       (bus.id_rt),
        .raw      (raw),
        .empty    (sb_empty)
    );

    always_comb begin
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        bubble_ex   = 1'b0;
        flush_id    = 1'b0;
        syscall_req = 1'b0;
        halted      = 1'b0;
        case (state)
            RUN: begin
                // A taken branch kills whatever sits in ID, so it outranks any stall.
                if (bus.branch_taken_ex) begin
                    flush_id  = 1'b1;
                    bubble_ex = 1'b1;
                end else if (raw || (bus.id_valid && bus.id_syscall)) begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                end
            end
            DRAIN: begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                bubble_ex = 1'b1;
            end
            SC_WAIT: begin
                syscall_req = 1'b1;
                if (!retire) begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                end
            end
            HALT: begin
                halted    = 1'b1;
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                bubble_ex = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            stall_count <= '0;
        end else begin
            if (stall_id && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            case (state)
                RUN: begin
                    if (!bus.branch_taken_ex && !raw && bus.id_valid && bus.id_syscall) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (sb_empty) begin
                        state <= SC_WAIT;
                    end
                end
                SC_WAIT: begin
                    if (bus.syscall_done) begin
                        state <= bus.syscall_halt ? HALT : RUN;
                    end
                end
                HALT: state <= HALT;
            endcase
        end
    end

    assign bus.stall_if    = stall_if;
    assign bus.stall_id    = stall_id;
    assign bus.bubble_ex   = bubble_ex;
    assign bus.flush_id    = flush_id;
    assign bus.syscall_req = syscall_req;
    assign bus.halted      = halted;
    assign bus.stall_count = stall_count;

endmodule

// File: tb/tb_hazard_scheduler.sv
// Scoreboard bench for hazard_scheduler: a pipeline-level reference model predicts each cycle's outputs.
module tb_hazard_scheduler;

    localparam int REG_W = 5;

    typedef struct {
        logic [5:0]  flags;
        logic [15:0] cnt;
        logic [3:0]  cnt4;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    exp_t expq[$];

    // Reference model: destinations still in flight (youngest first) and syscall progress.
    int  inflight[$];
    bit  m_halted;
    bit  m_drain;
    bit  m_grant;
    int  m_cnt16;
    int  m_cnt4;

    hazard_scheduler_if #(.REG_W(REG_W), .CNT_W(16)) bus ();
    hazard_scheduler_if #(.REG_W(REG_W), .CNT_W(4))  bus4 ();

    hazard_scheduler #(.REG_W(REG_W), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    hazard_scheduler #(.REG_W(REG_W), .CNT_W(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    assign bus4.id_valid        = bus.id_valid;
    assign bus4.id_rs           = bus.id_rs;
    assign bus4.id_rt           = bus.id_rt;
    assign bus4.id_wr_num       = bus.id_wr_num;
    assign bus4.id_jump         = bus.id_jump;
    assign bus4.id_syscall      = bus.id_syscall;
    assign bus4.branch_taken_ex = bus.branch_taken_ex;
    assign bus4.syscall_done    = bus.syscall_done;
    assign bus4.syscall_halt    = bus.syscall_halt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void model_reset();
        inflight = '{0, 0};
        m_halted = 1'b0;
        m_drain  = 1'b0;
        m_grant  = 1'b0;
        m_cnt16  = 0;
        m_cnt4   = 0;
    endfunction

    function automatic void push_zero();
        exp_t e;
        e.flags = '0;
        e.cnt   = '0;
        e.cnt4  = '0;
        e.cyc   = cyc;
        expq.push_back(e);
    endfunction

    task automatic doReset();
        @(negedge clk);
        rst_n                = 1'b0;
        bus.id_valid         = 1'b0;
        bus.id_rs            = '0;
        bus.id_rt            = '0;
        bus.id_wr_num        = '0;
        bus.id_jump          = 2'b00;
        bus.id_syscall       = 1'b0;
        bus.branch_taken_ex  = 1'b0;
        bus.syscall_done     = 1'b0;
        bus.syscall_halt     = 1'b0;
        model_reset();
        push_zero();
        @(negedge clk);
        push_zero();
        rst_n = 1'b1;
    endtask

    task automatic applyStimulus(input bit v, input int rs, input int rt, input int wr,
                                 input int jmp, input bit sc, input bit br,
                                 input bit dn, input bit hl);
        exp_t e;
        bit   raw;
        bit   s;
        bit   b;
        bit   f;
        bit   r;
        bit   h;
        bit   was_empty;
        @(negedge clk);
        bus.id_valid        = v;
        bus.id_rs           = REG_W'(rs);
        bus.id_rt           = REG_W'(rt);
        bus.id_wr_num       = REG_W'(wr);
        bus.id_jump         = 2'(jmp);
        bus.id_syscall      = sc;
        bus.branch_taken_ex = br;
        bus.syscall_done    = dn;
        bus.syscall_halt    = hl;

        raw = v && (jmp < 2) &&
              ((rs != 0 && (rs == inflight[0] || rs == inflight[1])) ||
               (rt != 0 && (rt == inflight[0] || rt == inflight[1])));
        s = 0; b = 0; f = 0; r = 0; h = 0;
        if (m_halted) begin
            s = 1; b = 1; h = 1;
        end else if (m_grant) begin
            r = 1;
            if (!(dn && !hl)) begin s = 1; b = 1; end
        end else if (m_drain) begin
            s = 1; b = 1;
        end else if (br) begin
            f = 1; b = 1;
        end else if (raw || (v && sc)) begin
            s = 1; b = 1;
        end
        e.flags = {s, s, b, f, r, h};
        e.cnt   = 16'(m_cnt16);
        e.cnt4  = 4'(m_cnt4);
        e.cyc   = cyc;
        expq.push_back(e);

        was_empty = (inflight[0] == 0) && (inflight[1] == 0);
        void'(inflight.pop_back());
        inflight.push_front((v && !s && !f && !h) ? wr : 0);
        if (s) begin
            if (m_cnt16 < 65535) m_cnt16++;
            if (m_cnt4 < 15) m_cnt4++;
        end
        if (m_halted) begin
        end else if (m_grant) begin
            if (dn) begin
                m_grant = 1'b0;
                if (hl) m_halted = 1'b1;
            end
        end else if (m_drain) begin
            if (was_empty) begin
                m_drain = 1'b0;
                m_grant = 1'b1;
            end
        end else if (!br && !raw && v && sc) begin
            m_drain = 1'b1;
        end
    endtask

    task automatic checkOutput(input exp_t e);
        logic [5:0] act;
        act = {bus.stall_if, bus.stall_id, bus.bubble_ex, bus.flush_id, bus.syscall_req, bus.halted};
        checks++;
        if (act !== e.flags) begin
            errors++;
            $display("[TB] FAIL flags cyc=%0d got=%b want=%b (if,id,bub,flush,req,halt)", e.cyc, act, e.flags);
        end
        checks++;
        if (bus.stall_count !== e.cnt) begin
            errors++;
            $display("[TB] FAIL stall_count cyc=%0d got=%0d want=%0d", e.cyc, bus.stall_count, e.cnt);
        end
        checks++;
        if (bus4.stall_count !== e.cnt4) begin
            errors++;
            $display("[TB] FAIL stall_count4 cyc=%0d got=%0d want=%0d", e.cyc, bus4.stall_count, e.cnt4);
        end
    endtask

    // Monitor: outputs are valid every cycle, sampled 2ns after inputs change, well before posedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                checkOutput(e);
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic hold_syscall(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1, 2, 0, 0, 0, 1, 0, 0, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        $display("[TB] starting");
        doReset();

        // Back-to-back RAW on r8.
        applyStimulus(1, 1, 2, 8, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 8, 0, 9, 0, 0, 0, 0, 0);
        idle(3);

        // Register 0 and j/jal never stall.
        applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 5, 0, 0, 0, 0, 0);
        applyStimulus(1, 5, 5, 0, 2, 0, 0, 0, 0);
        applyStimulus(1, 5, 0, 31, 3, 0, 0, 0, 0);
        idle(3);

        // Branch flush outranks a pending RAW.
        applyStimulus(1, 1, 1, 9, 0, 0, 0, 0, 0);
        applyStimulus(1, 9, 0, 4, 0, 0, 1, 0, 0);
        applyStimulus(1, 9, 0, 4, 0, 0, 0, 0, 0);
        idle(3);

        // Syscall with both pipeline slots busy, then resume.
        applyStimulus(1, 1, 1, 7, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 3, 0, 0, 0, 0, 0);
        hold_syscall(6);
        applyStimulus(1, 2, 0, 0, 0, 1, 0, 1, 0);
        idle(3);

        // Syscall ending in halt; stays halted, then reset mid-cycle.
        hold_syscall(4);
        applyStimulus(1, 2, 0, 0, 0, 1, 1, 1, 1);
        for (int i = 0; i < 100; i++)
            applyStimulus(1, 8, 8, 8, 0, 1, 1, 1, 0);
        doReset();

        // Randomized epochs, each restarted from reset.
        for (int ep = 0; ep < 6; ep++) begin
            for (int i = 0; i < 400; i++) begin
                bit dn;
                dn = ($urandom_range(0, 3) == 0);
                applyStimulus($urandom_range(0, 4) != 0,
                              int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                              int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                              $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
                              dn, dn && ($urandom_range(0, 7) == 0));
            end
            doReset();
        end

        idle(2);
        repeat (3) @(negedge clk);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("[TB] FAIL queue_drain got=%0d pending want=0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_scheduler.md
Name: hazard_scheduler

Overview:
- ID-stage pipeline sequencer for the 5-stage MIPS core. No forwarding paths.
- Keeps a 2-deep scoreboard of destination registers in flight (ID/EX, EX/MEM) and stalls IF/ID on RAW hazards.
- Inserts bubbles into ID/EX, flushes IF/ID on taken branches from EX, and runs the syscall drain/handshake/halt sequence.

Parameters:
- REG_W, 5, register-number width
- CNT_W, 16, stall performance counter width (saturating)

Ports:
- clk  in  1  system clock; all flops rise on posedge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs  in  REG_W  source register 1 (syscall id register when id_syscall=1)
- id_rt  in  REG_W  source register 2
- id_wr_num  in  REG_W  destination register of ID instruction; 0 = no write
- id_jump  in  2  00 none, 01 jr, 10 j, 11 jal
- id_syscall  in  1  ID instruction is syscall
- branch_taken_ex  in  1  EX resolved a taken branch this cycle
- syscall_done  in  1  syscall handler finished (1-cycle pulse)
- syscall_halt  in  1  qualifies syscall_done: handler requests halt
- stall_if  out  1  hold PC
- stall_id  out  1  hold IF/ID register
- bubble_ex  out  1  load NOP into ID/EX
- flush_id  out  1  clear IF/ID register
- syscall_req  out  1  level; syscall may execute
- halted  out  1  core halted
- stall_count  out  CNT_W  cycles with stall_id=1

Behaviour:
- Scoreboard: sb_ex, sb_mem (REG_W each). Every posedge: sb_mem<=sb_ex; sb_ex<=(issue ? id_wr_num : 0).
- issue = id_valid & ~stall_id & ~flush_id & ~halted.
- raw = id_valid & (id_jump==00 | id_jump==01) & (((id_rs==sb_ex)|(id_rs==sb_mem)) & id_rs!=0 | ((id_rt==sb_ex)|(id_rt==sb_mem)) & id_rt!=0).
- j/jal (10/11) never raise raw.
- FSM states: RUN, DRAIN, SC_WAIT, HALT. Register reset: RUN; sb_ex=sb_mem=0; stall_count=0.
- Output reset values: with id_valid held 0 during reset, every output is 0 and stall_count=0.
- RUN:
  - branch_taken_ex=1: flush_id=1, bubble_ex=1, stall_if=stall_id=0. This overrides raw and syscall.
  - Else raw=1: stall_if=stall_id=bubble_ex=1.
  - Else id_valid & id_syscall: stall_if=stall_id=bubble_ex=1; next state DRAIN.
- DRAIN:
  - Stall and bubble asserted.
  - When sb_ex==0 & sb_mem==0: next SC_WAIT.
  - Minimum 2 cycles after syscall enters ID.
- SC_WAIT:
  - syscall_req=1; stall and bubble asserted.
  - syscall_done & syscall_halt: next HALT.
  - syscall_done & ~syscall_halt: next RUN; syscall retires (bubble_ex=0 that cycle).
- HALT:
  - halted=1, stall_if=stall_id=bubble_ex=1; exited only by rst_n.
  - branch_taken_ex is ignored in HALT.
- Outputs are combinational from registered state plus ID inputs; zero-latency hazard detection within the ID cycle.
- stall_count increments each cycle stall_id=1 and saturates at all-ones.
- syscall_done outside SC_WAIT is ignored.
- A branch flush in DRAIN/SC_WAIT is impossible by construction (EX empty); it is ignored.
- rst_n assertion mid-stall or in any state returns to RUN within the same cycle (async) and clears the scoreboard.

Decomposition:
- Package hazard_pkg:
  - jump_t enum (J_NONE, J_JR, J_J, J_JAL)
  - sched_state_t enum (RUN, DRAIN, SC_WAIT, HALT)
  - REG_W constant
- Sub-module: hazard_scoreboard (2-stage dest-register shift, raw compare, empty flag).
- FSM, counter and output decode live in the top level.

Test Plan:
- Back-to-back RAW: cycle0 issue wr_num=8; cycle1 id_rs=8 -> stall_id=1,bubble_ex=1 for 2 cycles; issues cycle3; stall_count=2.
- Reg0 and j/jal: wr_num=0 then id_rs=0 -> no stall; wr_num=5 then id_jump=10, id_rs=5 -> no stall.
- Flush priority: raw pending and branch_taken_ex=1 same cycle -> flush_id=1,bubble_ex=1,stall_id=0; next cycle sb_ex=0.
- Syscall resume: id_syscall with sb_ex=3,sb_mem=7 -> DRAIN 2 cycles; SC_WAIT with syscall_req=1; syscall_done,halt=0 after 4 cycles -> RUN, syscall_req=0.
- Syscall halt and reset: syscall_done & syscall_halt -> halted=1, stalls held for 100 cycles; rst_n=0 mid-cycle -> halted=0 immediately, stall_count=0.
- Saturation with CNT_W=4: hold raw 20 cycles -> stall_count stops at 15.
